// File: rtl/sample_chain_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the sample chain sequencer:
//   seq_state_t  - sequencer FSM state, 2-bit encoding
//   DEF_*        - default parameter values used by the top level
//   sat_add      - saturating add of a small increment (0..3) to a counter
// ---------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CONV_EN   = 2'd1,
        CONV_WAIT = 2'd2,
        LAG_EN    = 2'd3
    } seq_state_t;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_CONV_EN_CYCLES = 2;
    localparam int DEF_TIMEOUT_CYCLES = 64;
    localparam int DEF_LAG_EN_CYCLES  = 1;
    localparam int DEF_CNT_W          = 16;

    // Adds inc to value and clamps at max_val. Evaluated one bit wider so
    // a counter already at the top cannot wrap before the clamp.
    function automatic logic [31:0] sat_add(input logic [31:0] value,
                                            input logic [1:0]  inc,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, value} + 33'(inc);
        if (sum > {1'b0, max_val})
            return max_val;
        return sum[31:0];
    endfunction

endpackage

// File: rtl/sample_tick_sync.sv
// ---------------------------------------------------------------------------
// sample_tick_sync
// Brings an asynchronous sample clock into the clk domain as data and turns
// each rising edge into a single-cycle registered tick.
//   clk         in   destination clock, rising edge
//   rst         in   synchronous active-high reset
//   sample_clk  in   asynchronous sample clock (treated as data)
//   tick        out  one-cycle pulse, SYNC_STAGES+1..+2 cycles after an edge
// SYNC_STAGES must be at least 2.
// ---------------------------------------------------------------------------
module sample_tick_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_clk,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync_pipe;
    logic                   prev;
    logic                   synced;

    assign synced = sync_pipe[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_pipe <= '0;
            prev      <= 1'b0;
            tick      <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], sample_clk};
            prev      <= synced;
            tick      <= synced & ~prev;
        end
    end

endmodule

// File: rtl/sample_chain_sequencer.sv
// ---------------------------------------------------------------------------
// sample_chain_sequencer
// Sequences one sample through sig16b_to_double and lag_generator: on each
// sample tick pulse conv_enable, wait (bounded) for conv_ready, then pulse
// lag_enable. Counts completed samples and dropped events.
//   clk_operation  in   system clock
//   rst            in   synchronous active-high reset
//   clk_samplying  in   asynchronous sample clock, used as data
//   run            in   gate for new ticks; in-flight sequences complete
//   conv_ready     in   ready from the converter (only honoured in CONV_WAIT)
//   conv_enable    out  converter enable, CONV_EN_CYCLES wide
//   lag_enable     out  lag generator enable, LAG_EN_CYCLES wide
//   busy           out  sequence in flight
//   overrun_err    out  sticky: tick arrived while busy
//   timeout_err    out  sticky: ready did not arrive in time
//   clear_err      in   clears sticky flags (a simultaneous set wins)
//   sample_count   out  completed sequences, wrapping
//   drop_count     out  overrun + timeout events, saturating
// CNT_W must not exceed 32.
// ---------------------------------------------------------------------------
module sample_chain_sequencer
    import seq_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int CONV_EN_CYCLES = DEF_CONV_EN_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int LAG_EN_CYCLES  = DEF_LAG_EN_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic             clk_operation,
    input  logic             rst,
    input  logic             clk_samplying,
    input  logic             run,
    input  logic             conv_ready,
    output logic             conv_enable,
    output logic             lag_enable,
    output logic             busy,
    output logic             overrun_err,
    output logic             timeout_err,
    input  logic             clear_err,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] drop_count
);

    // One down-counter is shared by all timed states, sized for the longest.
    localparam int CMAX_A = (CONV_EN_CYCLES > LAG_EN_CYCLES) ? CONV_EN_CYCLES : LAG_EN_CYCLES;
    localparam int CMAX   = (TIMEOUT_CYCLES > CMAX_A) ? TIMEOUT_CYCLES : CMAX_A;
    localparam int CW     = $clog2(CMAX + 1);

    localparam logic [CNT_W-1:0] DROP_MAX = '1;

    seq_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          tick;
    logic          timeout_evt;
    logic          done_evt;
    logic          overrun_evt;
    logic [1:0]    drop_inc;

    sample_tick_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_tick_sync (
        .clk        (clk_operation),
        .rst        (rst),
        .sample_clk (clk_samplying),
        .tick       (tick)
    );

    // A tick is only accepted from IDLE; any tick seen elsewhere is an
    // overrun, whatever run says, since it can never be serviced.
    assign overrun_evt = tick & (state != IDLE);
    assign drop_inc    = {1'b0, timeout_evt} + {1'b0, overrun_evt};

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        timeout_evt = 1'b0;
        done_evt    = 1'b0;
        case (state)
            IDLE: begin
                if (tick && run) begin
                    state_nxt = CONV_EN;
                    cnt_nxt   = CW'(CONV_EN_CYCLES);
                end
            end
            CONV_EN: begin
                // conv_ready is deliberately ignored here so a ready left
                // over from the previous sample cannot short-circuit the wait.
                if (cnt == CW'(1)) begin
                    state_nxt = CONV_WAIT;
                    cnt_nxt   = CW'(TIMEOUT_CYCLES);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            CONV_WAIT: begin
                if (conv_ready) begin
                    state_nxt = LAG_EN;
                    cnt_nxt   = CW'(LAG_EN_CYCLES);
                end else if (cnt == CW'(1)) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    timeout_evt = 1'b1;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            LAG_EN: begin
                if (cnt == CW'(1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    done_evt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_operation) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Outputs come straight from flops, decoded from the next state, so they
    // are glitch-free and line up exactly with the state they describe.
    always_ff @(posedge clk_operation) begin
        if (rst) begin
            conv_enable <= 1'b0;
            lag_enable  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            conv_enable <= (state_nxt == CONV_EN);
            lag_enable  <= (state_nxt == LAG_EN);
            busy        <= (state_nxt != IDLE);
        end
    end

    // Sticky flags: a set event in the same cycle as clear_err wins.
    always_ff @(posedge clk_operation) begin
        if (rst) begin
            overrun_err <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (overrun_evt)    overrun_err <= 1'b1;
            else if (clear_err) overrun_err <= 1'b0;
            if (timeout_evt)    timeout_err <= 1'b1;
            else if (clear_err) timeout_err <= 1'b0;
        end
    end

    always_ff @(posedge clk_operation) begin
        if (rst) begin
            sample_count <= '0;
            drop_count   <= '0;
        end else begin
            if (done_evt)
                sample_count <= sample_count + CNT_W'(1);
            if (drop_inc != 2'd0)
                drop_count <= CNT_W'(sat_add(32'(drop_count), drop_inc, 32'(DROP_MAX)));
        end
    end

endmodule

// File: tb/tb_sample_chain_sequencer.sv
// Two instances share all stimulus: A (LAG_EN_CYCLES=1, 16-bit counters)
// and B (LAG_EN_CYCLES=4, 2-bit counters so drop_count saturation shows up).
// A timestamp-based model predicts every output each cycle; directed
// literal checks pin the model against hand-computed values.
module tb_sample_chain_sequencer;

    localparam int CE = 2;
    localparam int TO = 8;
    localparam int S  = 2;
    localparam int LAGP [2] = '{1, 4};
    localparam int MAXD [2] = '{65535, 3};
    localparam int MODC [2] = '{65536, 4};

    logic clk = 1'b0, rst = 1'b1, cs = 1'b0, run = 1'b1, ready = 1'b0, clr = 1'b0;
    logic conv_a, lag_a, busy_a, ov_a, to_a;
    logic conv_b, lag_b, busy_b, ov_b, to_b;
    logic [15:0] sc_a, dc_a;
    logic [1:0]  sc_b, dc_b;

    int  total = 0;
    int  bad   = 0;
    bit  chk_en = 1'b0;

    always #5 clk = ~clk;

    sample_chain_sequencer #(.SYNC_STAGES(S), .CONV_EN_CYCLES(CE), .TIMEOUT_CYCLES(TO),
                             .LAG_EN_CYCLES(1), .CNT_W(16)) dut_a (
        .clk_operation(clk), .rst(rst), .clk_samplying(cs), .run(run),
        .conv_ready(ready), .conv_enable(conv_a), .lag_enable(lag_a), .busy(busy_a),
        .overrun_err(ov_a), .timeout_err(to_a), .clear_err(clr),
        .sample_count(sc_a), .drop_count(dc_a));

    sample_chain_sequencer #(.SYNC_STAGES(S), .CONV_EN_CYCLES(CE), .TIMEOUT_CYCLES(TO),
                             .LAG_EN_CYCLES(4), .CNT_W(2)) dut_b (
        .clk_operation(clk), .rst(rst), .clk_samplying(cs), .run(run),
        .conv_ready(ready), .conv_enable(conv_b), .lag_enable(lag_b), .busy(busy_b),
        .overrun_err(ov_b), .timeout_err(to_b), .clear_err(clr),
        .sample_count(sc_b), .drop_count(dc_b));

    // ---------------- model: sequence start / lag start timestamps ----------
    int cyc = 0;
    bit [S+1:0] h;
    bit tq;
    int m_act[2], m_t0[2], m_tl[2], m_sc[2], m_dc[2], m_ov[2], m_to[2];

    initial begin
        h = '0; tq = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_t0[i] = 0; m_tl[i] = -1;
            m_sc[i] = 0; m_dc[i] = 0; m_ov[i] = 0; m_to[i] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                h = '0; tq = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    m_act[i] = 0; m_t0[i] = 0; m_tl[i] = -1;
                    m_sc[i] = 0; m_dc[i] = 0; m_ov[i] = 0; m_to[i] = 0;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    int endc, ev;
                    bit was_busy, sov, sto;
                    was_busy = (m_act[i] != 0);
                    ev = 0; sov = 0; sto = 0;
                    // ready counts only once the enable window is over
                    if (m_act[i] != 0 && m_tl[i] < 0 && ready && (cyc - 1) >= m_t0[i] + CE)
                        m_tl[i] = cyc;
                    endc = (m_tl[i] >= 0) ? m_tl[i] + LAGP[i] : m_t0[i] + CE + TO;
                    if (m_act[i] != 0 && cyc == endc) begin
                        if (m_tl[i] >= 0) m_sc[i] = (m_sc[i] + 1) % MODC[i];
                        else begin sto = 1; ev++; end
                        m_act[i] = 0;
                    end
                    if (tq) begin
                        if (was_busy) begin sov = 1; ev++; end
                        else if (run) begin m_act[i] = 1; m_t0[i] = cyc; m_tl[i] = -1; end
                    end
                    if (sov) m_ov[i] = 1; else if (clr) m_ov[i] = 0;
                    if (sto) m_to[i] = 1; else if (clr) m_to[i] = 0;
                    m_dc[i] = (m_dc[i] + ev > MAXD[i]) ? MAXD[i] : m_dc[i] + ev;
                end
                h  = {h[S:0], cs};
                tq = h[S] & ~h[S+1];
            end
        end
    end

    // ---------------- per-cycle compare ------------------------------------
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [36:0] got, exp;
                bit e_conv, e_lag;
                e_conv = (m_act[i] != 0) && (cyc - m_t0[i] < CE);
                e_lag  = (m_act[i] != 0) && (m_tl[i] >= 0) && (cyc >= m_tl[i]);
                exp = {e_conv, e_lag, m_act[i] != 0, m_ov[i] != 0, m_to[i] != 0,
                       16'(m_sc[i]), 16'(m_dc[i])};
                if (i == 0) got = {conv_a, lag_a, busy_a, ov_a, to_a, sc_a, dc_a};
                else        got = {conv_b, lag_b, busy_b, ov_b, to_b, 14'd0, sc_b, 14'd0, dc_b};
                total++;
                if (got !== exp) begin
                    bad++;
                    $display("FAIL model_cmp[%0d] cyc=%0d: got %h expected %h", i, cyc, got, exp);
                end
            end
        end
    end

    // ---------------- helpers -----------------------------------------------
    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit sig_of(input int sel);
        case (sel)
            0: return conv_a;
            1: return lag_a;
            2: return conv_b;
            3: return lag_b;
            4: return !busy_a;
            default: return !busy_b;
        endcase
    endfunction

    task automatic wait_sig(input string nm, input int sel);
        int n;
        n = 0;
        while (!sig_of(sel) && n < 64) begin step(1); n++; end
        if (!sig_of(sel)) begin
            total++; bad++;
            $display("FAIL wait_%s: got no event expected one within 64 cycles", nm);
        end
    endtask

    task automatic width(input int sel, output int w);
        w = 0;
        while (sig_of(sel) && w < 32) begin w++; step(1); end
    endtask

    task automatic do_reset();
        rst = 1'b1; step(1); rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    // ---------------- directed stimulus -------------------------------------
    initial begin
        int w, n;
        bit seen;
        step(2);
        chk("rst_conv", conv_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_counts", {sc_a, dc_a}, 0);
        rst = 1'b0;
        chk_en = 1'b1;
        step(2);

        // 1: single sample
        cs = 1'b1;
        wait_sig("conv_t1", 0);
        cs = 1'b0;
        width(0, w);
        chk("t1_conv_width", w, 2);
        step(4); ready = 1'b1;
        wait_sig("lag_t1", 1);
        ready = 1'b0;
        width(1, w);
        chk("t1_lag_width", w, 1);
        step(4);
        chk("t1_sample_a", sc_a, 1);
        chk("t1_sample_b", sc_b, 1);
        chk("t1_busy", busy_a, 0);
        chk("t1_errs", {ov_a, to_a, dc_a}, 0);

        // 2: timeout
        do_reset();
        cs = 1'b1;
        wait_sig("conv_t2", 0);
        cs = 1'b0;
        n = 0; seen = 1'b0;
        while (busy_a && n < 40) begin seen |= lag_a; n++; step(1); end
        chk("t2_busy_len", n, CE + TO);
        chk("t2_no_lag", seen, 0);
        chk("t2_timeout", to_a, 1);
        chk("t2_drop", dc_a, 1);
        clr = 1'b1; step(1); clr = 1'b0;
        chk("t2_clear", to_a, 0);
        chk("t2_drop_kept", dc_a, 1);

        // 3: overrun during CONV_WAIT
        do_reset();
        cs = 1'b1;
        wait_sig("conv_t3", 0);
        cs = 1'b0; step(2);
        cs = 1'b1; step(5);
        ready = 1'b1; step(1); ready = 1'b0;
        wait_sig("idle_t3", 5);
        chk("t3_overrun", ov_a, 1);
        chk("t3_drop", dc_a, 1);
        chk("t3_sample", sc_a, 1);
        chk("t3_no_timeout", to_a, 0);
        cs = 1'b0;

        // 4: stale ready held through CONV_EN
        do_reset();
        step(3);
        ready = 1'b1; cs = 1'b1;
        wait_sig("conv_t4", 0);
        cs = 1'b0;
        width(0, w);
        chk("t4_conv_width", w, 2);
        chk("t4_no_early_lag", lag_a, 0);
        chk("t4_busy", busy_a, 1);
        step(1);
        chk("t4_lag_rise", lag_a, 1);
        ready = 1'b0;
        wait_sig("idle_t4", 5);

        // 5: reset in the middle of B's 4-cycle lag pulse
        do_reset();
        step(3);
        cs = 1'b1;
        wait_sig("conv_t5", 2);
        cs = 1'b0; step(3);
        ready = 1'b1;
        wait_sig("lag_t5", 3);
        ready = 1'b0;
        step(1);
        chk("t5_lag_2nd", lag_b, 1);
        rst = 1'b1; step(1); rst = 1'b0;
        chk("t5_lag_off", lag_b, 0);
        chk("t5_busy_off", busy_b, 0);
        chk("t5_counts", {sc_b, dc_b, sc_a, dc_a}, 0);

        // 6: gated ticks, then clear colliding with an overrun
        step(3);
        run = 1'b0; seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cs = 1'b1;
            for (int j = 0; j < 4; j++) begin seen |= conv_a | lag_a | busy_a | ov_a | to_a; step(1); end
            cs = 1'b0;
            for (int j = 0; j < 4; j++) begin seen |= conv_a | lag_a | busy_a | ov_a | to_a; step(1); end
        end
        chk("t6_gated", seen, 0);
        run = 1'b1;
        cs = 1'b1;
        wait_sig("conv_t6", 0);
        cs = 1'b0; step(2);
        cs = 1'b1; step(3);
        clr = 1'b1; step(1); clr = 1'b0;
        chk("t6_set_wins", ov_a, 1);
        chk("t6_drop", dc_a, 1);
        step(1);
        ready = 1'b1; step(1); ready = 1'b0;
        wait_sig("idle_t6", 5);
        chk("t6_sample", sc_a, 1);
        clr = 1'b1; step(1); clr = 1'b0;
        chk("t6_cleared", ov_a, 0);
        cs = 1'b0;

        // 7: timeout and overrun on the same edge, twice (B saturates at 3)
        do_reset();
        for (int r = 0; r < 2; r++) begin
            cs = 1'b0; step(4);
            cs = 1'b1;
            wait_sig("conv_t7", 0);
            cs = 1'b0; step(6);
            cs = 1'b1;
            wait_sig("idle_t7", 4);
            chk("t7_both_flags", {ov_a, to_a}, 2'b11);
            chk("t7_drop_a", dc_a, 2 * (r + 1));
            chk("t7_drop_b_sat", dc_b, (r == 0) ? 2 : 3);
        end
        cs = 1'b0;

        step(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
